// File: rtl/alu_writeback_stage_if.sv
// Handshake bundle between the ALU output and the writeback stage,
// and between the stage and the register-file write port.
interface alu_writeback_stage_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [4:0]       in_opcode;
   logic [TAG_W-1:0] in_dest;
   logic [WIDTH-1:0] in_r;
   logic             in_negative;
   logic             in_zero;
   logic             in_cout;
   logic             in_overflow;
   logic             in_div_invalid;
   logic             wb_valid;
   logic             wb_ready;
   logic [TAG_W-1:0] wb_dest;
   logic [WIDTH-1:0] wb_data;

   // ALU/producer side: drives beats in, consumes writeback.
   modport master (
      output in_valid, in_opcode, in_dest, in_r, in_negative, in_zero,
             in_cout, in_overflow, in_div_invalid, wb_ready,
      input  in_ready, wb_valid, wb_dest, wb_data
   );

   // Stage side.
   modport slave (
      input  in_valid, in_opcode, in_dest, in_r, in_negative, in_zero,
             in_cout, in_overflow, in_div_invalid, wb_ready,
      output in_ready, wb_valid, wb_dest, wb_data
   );
endinterface

// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: 2-entry in-order skid FIFO toward the register file,
// architectural CPSR {N,Z,C,V}, sticky division-fault status with a
// saturating fault counter. Optional performance counters are enabled by
// defining ALU_WB_PERF_EN.
module alu_writeback_stage #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned TAG_W  = 4,
   parameter int unsigned FCNT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   alu_writeback_stage_if.slave bus,
   output logic [3:0]        cpsr,
   output logic              div_fault,
   output logic [FCNT_W-1:0] fault_cnt,
   input  logic              fault_clear
`ifdef ALU_WB_PERF_EN
   ,
   output logic [31:0]       perf_ops,
   output logic [31:0]       perf_stall
`endif
);

   localparam int unsigned DEPTH = 2;
   localparam logic [4:0]  OP_CMP_A = 5'b00101;
   localparam logic [4:0]  OP_CMP_B = 5'b11110;
   localparam logic [4:0]  OP_DIV   = 5'b01101;

   typedef struct packed {
      logic [TAG_W-1:0] dest;
      logic [WIDTH-1:0] data;
   } entry_t;

   entry_t            mem_q [DEPTH];
   entry_t            mem_d [DEPTH];
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [1:0]        count_q, count_d;
   logic [3:0]        cpsr_q, cpsr_d;
   logic              div_fault_q, div_fault_d;
   logic [FCNT_W-1:0] fault_cnt_q, fault_cnt_d;

   logic accept, is_cmp, is_div_fault, push, pop;

   // Handshake and classification of the current beat.
   always_comb begin
      accept       = bus.in_valid && bus.in_ready;
      is_cmp       = (bus.in_opcode == OP_CMP_A) || (bus.in_opcode == OP_CMP_B);
      is_div_fault = (bus.in_opcode == OP_DIV) && bus.in_div_invalid;
      push         = accept && !is_cmp && !is_div_fault;
      pop          = bus.wb_valid && bus.wb_ready;
   end

   // Next-state for FIFO pointers/storage, CPSR and fault status.
   always_comb begin
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q + 2'(push) - 2'(pop);
      cpsr_d      = cpsr_q;
      div_fault_d = div_fault_q;
      fault_cnt_d = fault_cnt_q;

      if (push) begin
         mem_d[wr_ptr_q] = '{dest: bus.in_dest, data: bus.in_r};
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end

      if (accept && !is_div_fault) begin
         cpsr_d = {bus.in_negative, bus.in_zero, bus.in_cout, bus.in_overflow};
      end

      // A fault accepted together with a clear restarts the count at one.
      if (accept && is_div_fault) begin
         div_fault_d = 1'b1;
         if (fault_clear) begin
            fault_cnt_d = FCNT_W'(1);
         end else if (fault_cnt_q != '1) begin
            fault_cnt_d = fault_cnt_q + FCNT_W'(1);
         end
      end else if (fault_clear) begin
         div_fault_d = 1'b0;
         fault_cnt_d = '0;
      end
   end

   // Control/status registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         count_q     <= 2'd0;
         cpsr_q      <= 4'b0000;
         div_fault_q <= 1'b0;
         fault_cnt_q <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         cpsr_q      <= cpsr_d;
         div_fault_q <= div_fault_d;
         fault_cnt_q <= fault_cnt_d;
      end
   end

   // FIFO payload storage; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign bus.in_ready = (count_q != 2'd2);
   assign bus.wb_valid = (count_q != 2'd0);
   assign bus.wb_dest  = mem_q[rd_ptr_q].dest;
   assign bus.wb_data  = mem_q[rd_ptr_q].data;
   assign cpsr         = cpsr_q;
   assign div_fault    = div_fault_q;
   assign fault_cnt    = fault_cnt_q;

`ifdef ALU_WB_PERF_EN
   logic [31:0] perf_ops_q, perf_ops_d;
   logic [31:0] perf_stall_q, perf_stall_d;

   // Wrapping counters of accepted beats and input stall cycles.
   always_comb begin
      perf_ops_d   = perf_ops_q + 32'(accept);
      perf_stall_d = perf_stall_q + 32'(bus.in_valid && !bus.in_ready);
   end

   // Performance counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_ops_q   <= 32'd0;
         perf_stall_q <= 32'd0;
      end else begin
         perf_ops_q   <= perf_ops_d;
         perf_stall_q <= perf_stall_d;
      end
   end

   assign perf_ops   = perf_ops_q;
   assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Self-checking bench for alu_writeback_stage: directed steps followed by
// randomized traffic, checked against a queue-based reference model.
module tb_alu_writeback_stage;

   logic       clk;
   logic       rst;
   logic [3:0] cpsr;
   logic       div_fault;
   logic [7:0] fault_cnt;
   logic       fault_clear;
`ifdef ALU_WB_PERF_EN
   logic [31:0] perf_ops, perf_stall;
   int unsigned m_ops, m_stall;
`endif

   alu_writeback_stage_if #(.WIDTH(16), .TAG_W(4)) bus ();

   alu_writeback_stage #(.WIDTH(16), .TAG_W(4), .FCNT_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .cpsr        (cpsr),
      .div_fault   (div_fault),
      .fault_cnt   (fault_cnt),
      .fault_clear (fault_clear)
`ifdef ALU_WB_PERF_EN
      ,
      .perf_ops    (perf_ops),
      .perf_stall  (perf_stall)
`endif
   );

   always #5 clk = ~clk;

   int n_err;
   int n_checks;

   // Reference model state.
   logic [3:0]  q_dest[$];
   logic [15:0] q_data[$];
   logic [3:0]  m_cpsr;
   logic        m_fault;
   int          m_cnt;
   logic [15:0] obs_q[$];
   bit          last_acc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [4:0] op, input logic [3:0] dest,
                        input logic [15:0] r, input logic [3:0] nzcv, input logic dv);
      bus.in_valid       = v;
      bus.in_opcode      = op;
      bus.in_dest        = dest;
      bus.in_r           = r;
      bus.in_negative    = nzcv[3];
      bus.in_zero        = nzcv[2];
      bus.in_cout        = nzcv[1];
      bus.in_overflow    = nzcv[0];
      bus.in_div_invalid = dv;
   endtask

   task automatic check_all();
      chk("in_ready", 32'(bus.in_ready), 32'(q_data.size() < 2));
      chk("wb_valid", 32'(bus.wb_valid), 32'(q_data.size() != 0));
      if (q_data.size() != 0) begin
         chk("wb_dest", 32'(bus.wb_dest), 32'(q_dest[0]));
         chk("wb_data", 32'(bus.wb_data), 32'(q_data[0]));
      end
      chk("cpsr", 32'(cpsr), 32'(m_cpsr));
      chk("div_fault", 32'(div_fault), 32'(m_fault));
      chk("fault_cnt", 32'(fault_cnt), 32'(m_cnt));
`ifdef ALU_WB_PERF_EN
      chk("perf_ops", perf_ops, m_ops);
      chk("perf_stall", perf_stall, m_stall);
`endif
   endtask

   // One clock: evaluate the model on the current inputs, clock, then compare.
   task automatic cycle();
      bit pop, acc, cmp, divf;
      logic [3:0] nzcv;
      pop  = (q_data.size() != 0) && bus.wb_ready;
      acc  = bus.in_valid && (q_data.size() < 2);
      cmp  = (bus.in_opcode == 5'd5) || (bus.in_opcode == 5'd30);
      divf = (bus.in_opcode == 5'd13) && bus.in_div_invalid;
      nzcv = {bus.in_negative, bus.in_zero, bus.in_cout, bus.in_overflow};
      if (!rst && bus.wb_valid === 1'b1 && bus.wb_ready) obs_q.push_back(bus.wb_data);
      @(posedge clk);
      #1;
      last_acc = !rst && acc;
      if (rst) begin
         q_dest.delete();
         q_data.delete();
         m_cpsr  = 4'b0000;
         m_fault = 1'b0;
         m_cnt   = 0;
`ifdef ALU_WB_PERF_EN
         m_ops   = 0;
         m_stall = 0;
`endif
      end else begin
`ifdef ALU_WB_PERF_EN
         if (acc) m_ops++;
         if (bus.in_valid && !acc) m_stall++;
`endif
         if (pop) begin
            void'(q_dest.pop_front());
            void'(q_data.pop_front());
         end
         if (acc && !cmp && !divf) begin
            q_dest.push_back(bus.in_dest);
            q_data.push_back(bus.in_r);
         end
         if (acc && !divf) m_cpsr = nzcv;
         if (acc && divf) begin
            m_fault = 1'b1;
            m_cnt   = fault_clear ? 1 : ((m_cnt == 255) ? 255 : m_cnt + 1);
         end else if (fault_clear) begin
            m_fault = 1'b0;
            m_cnt   = 0;
         end
      end
      check_all();
   endtask

   initial begin
      logic [4:0] op;
      n_err = 0;
      n_checks = 0;
      clk = 1'b0;
      rst = 1'b1;
      fault_clear = 1'b0;
      bus.wb_ready = 1'b0;
      drive(1'b0, 5'd0, 4'd0, 16'd0, 4'b0000, 1'b0);
      m_cpsr = 4'b0000;
      m_fault = 1'b0;
      m_cnt = 0;
`ifdef ALU_WB_PERF_EN
      m_ops = 0;
      m_stall = 0;
`endif
      @(negedge clk);

      // Reset.
      cycle();
      cycle();
      rst = 1'b0;
      chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
      chk("rst_cpsr", 32'(cpsr), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

      // Single add beat.
      bus.wb_ready = 1'b1;
      drive(1'b1, 5'b00001, 4'd3, 16'h0005, 4'b0010, 1'b0);
      cycle();
      chk("add_wb_valid", 32'(bus.wb_valid), 32'd1);
      chk("add_wb_dest", 32'(bus.wb_dest), 32'd3);
      chk("add_wb_data", 32'(bus.wb_data), 32'h0005);
      chk("add_cpsr", 32'(cpsr), 32'b0010);
      drive(1'b0, 5'd0, 4'd0, 16'd0, 4'b0000, 1'b0);
      cycle();
      chk("add_drained", 32'(bus.wb_valid), 32'd0);

      // Backpressure: three beats with the register file stalled.
      obs_q.delete();
      bus.wb_ready = 1'b0;
      drive(1'b1, 5'b00010, 4'd1, 16'd1, 4'b0000, 1'b0);
      cycle();
      drive(1'b1, 5'b00010, 4'd2, 16'd2, 4'b0000, 1'b0);
      cycle();
      chk("bp_full_ready", 32'(bus.in_ready), 32'd0);
      drive(1'b1, 5'b00010, 4'd3, 16'd3, 4'b0000, 1'b0);
      cycle();
      chk("bp_head_held", 32'(bus.wb_data), 32'd1);
      bus.wb_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (last_acc) break;
      end
      drive(1'b0, 5'd0, 4'd0, 16'd0, 4'b0000, 1'b0);
      for (int i = 0; i < 4; i++) cycle();
      chk("bp_count", 32'(obs_q.size()), 32'd3);
      for (int i = 0; i < 3; i++) begin
         logic [15:0] o;
         o = (i < obs_q.size()) ? obs_q[i] : 16'hxxxx;
         chk("bp_order", 32'(o), 32'(i + 1));
      end

      // Compare: flags only, no writeback.
      drive(1'b1, 5'b00101, 4'd7, 16'hFFFF, 4'b0100, 1'b0);
      cycle();
      chk("cmp_no_push", 32'(bus.wb_valid), 32'd0);
      chk("cmp_cpsr", 32'(cpsr), 32'b0100);

      // Division fault leaves CPSR alone.
      drive(1'b1, 5'b00000, 4'd4, 16'h8000, 4'b1000, 1'b0);
      cycle();
      drive(1'b1, 5'b01101, 4'd5, 16'h1234, 4'b0111, 1'b1);
      cycle();
      chk("div_cpsr", 32'(cpsr), 32'b1000);
      chk("div_fault", 32'(div_fault), 32'd1);
      chk("div_cnt", 32'(fault_cnt), 32'd1);
      chk("div_no_push", 32'(bus.wb_valid), 32'd0);
      for (int i = 0; i < 300; i++) cycle();
      chk("div_sat", 32'(fault_cnt), 32'hFF);

      // Clear racing a fault: set wins.
      fault_clear = 1'b1;
      cycle();
      chk("clr_race_fault", 32'(div_fault), 32'd1);
      chk("clr_race_cnt", 32'(fault_cnt), 32'd1);
      drive(1'b0, 5'd0, 4'd0, 16'd0, 4'b0000, 1'b0);
      cycle();
      fault_clear = 1'b0;
      chk("clr_fault", 32'(div_fault), 32'd0);
      chk("clr_cnt", 32'(fault_cnt), 32'd0);

      // Reset with two buffered entries.
      bus.wb_ready = 1'b0;
      drive(1'b1, 5'b00011, 4'd8, 16'hAAAA, 4'b1111, 1'b0);
      cycle();
      drive(1'b1, 5'b00011, 4'd9, 16'hBBBB, 4'b1111, 1'b0);
      cycle();
      chk("pre_rst_full", 32'(bus.in_ready), 32'd0);
      chk("pre_rst_cpsr", 32'(cpsr), 32'b1111);
      drive(1'b0, 5'd0, 4'd0, 16'd0, 4'b0000, 1'b0);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("mid_rst_valid", 32'(bus.wb_valid), 32'd0);
      chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
      chk("mid_rst_cpsr", 32'(cpsr), 32'd0);

      // Randomized traffic.
      for (int i = 0; i < 500; i++) begin
         case ($urandom_range(0, 4))
            0: op = 5'b00101;
            1: op = 5'b11110;
            2: op = 5'b01101;
            default: op = 5'($urandom);
         endcase
         drive(1'($urandom_range(0, 3) != 0), op, 4'($urandom), 16'($urandom),
               4'($urandom), 1'($urandom));
         bus.wb_ready = 1'($urandom_range(0, 2) != 0);
         fault_clear  = ($urandom_range(0, 15) == 0);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_writeback_stage.md
Name: alu_writeback_stage

Overview:
Registered stage directly downstream of the combinational 16-bit ALU. Captures each ALU result, its flags, its opcode and a destination tag under a valid/ready handshake. Buffers results in a 2-entry skid FIFO toward the register-file write port and maintains the architectural CPSR (N,Z,C,V). Records division-by-invalid faults in sticky status.

Parameters:
WIDTH, 16, result/data width; must match the ALU WIDTH
TAG_W, 4, destination register tag width
FCNT_W, 8, fault counter width (saturating)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  ALU output beat valid
in_ready  out  1  stage can accept a beat
in_opcode  in  5  opcode that produced the beat
in_dest  in  TAG_W  destination register tag
in_r  in  WIDTH  ALU result r
in_negative  in  1  ALU N flag
in_zero  in  1  ALU Z flag
in_cout  in  1  ALU C flag
in_overflow  in  1  ALU V flag
in_div_invalid  in  1  ALU division_invalid_flag
wb_valid  out  1  writeback beat valid (FIFO non-empty)
wb_ready  in  1  register file accepts writeback
wb_dest  out  TAG_W  head-entry tag
wb_data  out  WIDTH  head-entry data
cpsr  out  4  {N,Z,C,V}, registered
div_fault  out  1  sticky division fault
fault_cnt  out  FCNT_W  saturating count of division faults
fault_clear  in  1  clears div_fault and fault_cnt

Behaviour:
- Clocking and reset: all state updates on posedge clk. When rst=1, FIFO count becomes 0, wb_valid=0, cpsr=4'b0000, div_fault=0 and fault_cnt=0. FIFO data is don't-care after reset. Reset mid-operation drops all buffered beats with no writeback.
- Handshakes: in_ready = (count != 2), driven only from registered state. Accept occurs when in_valid && in_ready. Pop occurs when wb_valid && wb_ready. wb_dest and wb_data present the head entry and hold stable while wb_valid && !wb_ready.
- Classification of an accepted beat:
  - Compare (opcode 00101 or 11110): no push. cpsr <= {N,Z,C,V}.
  - Divide (01101) with in_div_invalid=1: no push and cpsr unchanged. div_fault <= 1. fault_cnt increments, saturating at all-ones.
  - All other opcodes, including unlisted encodings: push {in_dest, in_r}. cpsr <= {N,Z,C,V}.
- Latency: a pushed beat is visible on wb_* the cycle after acceptance. There is no combinational path from in_* to wb_*. cpsr updates the cycle after acceptance.
- FIFO order: 2 entries, strict in-order.
  - Push and pop in the same cycle at count 1: count stays 1 and the new entry becomes head.
  - At count 2, push is impossible because in_ready=0. A pop at count 2 raises in_ready on the next cycle.
  - Pop at count 0 is impossible because wb_valid=0.
  - Pointers wrap modulo 2.
- Fault clear: fault_clear clears div_fault and fault_cnt next cycle. If a fault is accepted in the same cycle, the set wins: div_fault=1 and fault_cnt=1.
- Other inputs: when in_valid=0, all in_* are ignored. in_div_invalid is ignored for opcodes other than 01101.

Optional Feature:
ALU_WB_PERF_EN
- Defined: adds outputs perf_ops (32-bit, increments on every accepted beat) and perf_stall (32-bit, increments each cycle in_valid && !in_ready). Both wrap around, reset to 0, and are unaffected by fault_clear.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then add beat (opcode 00001, dest 3, r=16'h0005, N=0 Z=0 C=1 V=0) with wb_ready=1 -> next cycle wb_valid=1, wb_dest=3, wb_data=0005, cpsr=4'b0010; following cycle wb_valid=0.
- Hold wb_ready=0 and send 3 back-to-back beats r=1,2,3 -> in_ready drops after the 2nd accept, beat 3 stalls; raise wb_ready -> outputs 1,2,3 in order, none lost or duplicated.
- Compare beat (opcode 00101, Z=1, r=FFFF) -> no wb_valid; cpsr=4'b0100.
- Divide beat (01101) with in_div_invalid=1, prior cpsr=4'b1000 -> no push, cpsr stays 1000, div_fault=1, fault_cnt=1; 300 further faults -> fault_cnt=FF.
- fault_clear asserted in the same cycle as a fault accept -> div_fault=1, fault_cnt=1; fault_clear alone -> both 0.
- Assert rst with 2 buffered entries and cpsr=1111 -> next cycle wb_valid=0, in_ready=1, cpsr=0000.
